// File: rtl/i2c_reg_ctrl.sv
// i2c_reg_ctrl: register-access sequencer in front of a byte-level I2C master.
// Takes one command, drives the master's Start/Write/Read/Stop strobes byte by
// byte, pulls write data from a valid/ready stream and pushes read bytes out
// as single-cycle valid pulses. Ends each transaction with an oDone pulse and a
// 2-bit error code.
module i2c_reg_ctrl #(
   parameter int CLK_FREQ    = 100_000_000,
   parameter int I2C_FREQ    = 100_000,
   parameter int LEN_W       = 4,
   parameter int TIMEOUT_CYC = 200_000
) (
   input  logic             iClk,
   input  logic             iRst_n,
   input  logic             iCmd_Valid,
   output logic             oCmd_Ready,
   input  logic             iCmd_Rw,
   input  logic [6:0]       iCmd_Dev,
   input  logic [7:0]       iCmd_Reg,
   input  logic [LEN_W-1:0] iCmd_Len,
   input  logic [7:0]       iWr_Data,
   input  logic             iWr_Valid,
   output logic             oWr_Ready,
   output logic [7:0]       oRd_Data,
   output logic             oRd_Valid,
   output logic             oDone,
   output logic [1:0]       oErr,
   output logic             oBusy,
   output logic             oI2C_Start,
   output logic             oI2C_Write,
   output logic             oI2C_Read,
   output logic             oI2C_Stop,
   output logic [7:0]       oI2C_TxData,
   input  logic             iI2C_TxDone,
   input  logic             iI2C_TxReady,
   input  logic             iI2C_RxDone,
   input  logic [7:0]       iI2C_RxData
);

   // Length of the master's STOP sequence in system clocks, plus the last
   // timer value of the STOP wait and of a master-event wait.
   localparam int          STOP_CYC     = CLK_FREQ / I2C_FREQ;
   localparam logic [31:0] STOP_LAST    = 32'(STOP_CYC + 1);
   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_REG, S_WREQ, S_WDATA, S_RADDR,
      S_READ, S_STOP, S_STOP_WAIT, S_DONE
   } state_t;

   // Byte states go through issue (strobe), wait (for the master's done
   // pulse) and, for transmitted bytes, a single ACK-check cycle.
   typedef enum logic [1:0] {
      PH_ISSUE, PH_WAIT, PH_ACK
   } phase_t;

   state_t           r_state, w_stateNext;
   phase_t           r_phase, w_phaseNext;
   logic [6:0]       r_dev;
   logic [7:0]       r_reg;
   logic             r_rw;
   logic [LEN_W-1:0] r_cnt;
   logic [31:0]      r_timer;
   logic [7:0]       r_txData;
   logic [1:0]       r_err;
   logic [7:0]       r_rdData;
   logic             r_rdValid;

   logic             w_start, w_write, w_read, w_stop;
   logic             w_accept, w_txLoad, w_errSet, w_cntDec, w_tmo;
   logic [7:0]       w_txNext;
   logic [1:0]       w_errVal;
   logic             w_expired, w_lastByte, w_rxCapture;

   assign w_expired   = (r_timer >= TIMEOUT_LAST);
   assign w_lastByte  = (r_cnt == LEN_W'(1));
   assign w_rxCapture = iI2C_RxDone && (r_state == S_READ) && (r_phase == PH_WAIT);

   // Next-state and strobe decode. A byte state only strobes when the master
   // is holding (TxReady), except the very first Start of a transaction.
   // Any wait on the master that runs out of time ends the transaction with
   // error 3, closing the bus with a Stop if the master can still take one.
   always_comb begin
      w_stateNext = r_state;
      w_phaseNext = r_phase;
      w_start     = 1'b0;
      w_write     = 1'b0;
      w_read      = 1'b0;
      w_stop      = 1'b0;
      w_accept    = 1'b0;
      w_txLoad    = 1'b0;
      w_txNext    = r_txData;
      w_errSet    = 1'b0;
      w_errVal    = 2'd0;
      w_cntDec    = 1'b0;
      w_tmo       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (iCmd_Valid) begin
               w_accept    = 1'b1;
               w_stateNext = S_ADDR;
               w_txLoad    = 1'b1;
               w_txNext    = {iCmd_Dev, 1'b0};
            end
         end
         S_ADDR, S_REG, S_WDATA, S_RADDR: begin
            case (r_phase)
               PH_ISSUE: begin
                  if ((r_state == S_ADDR) || iI2C_TxReady) begin
                     w_start     = (r_state == S_ADDR) || (r_state == S_RADDR);
                     w_write     = (r_state == S_REG) || (r_state == S_WDATA);
                     w_phaseNext = PH_WAIT;
                  end else begin
                     w_tmo = w_expired;
                  end
               end
               PH_WAIT: begin
                  if (iI2C_TxDone) begin
                     w_phaseNext = PH_ACK;
                  end else begin
                     w_tmo = w_expired;
                  end
               end
               default: begin
                  if (!iI2C_TxReady) begin
                     w_errSet    = 1'b1;
                     w_errVal    = ((r_state == S_ADDR) || (r_state == S_RADDR)) ? 2'd1 : 2'd2;
                     w_stateNext = S_STOP_WAIT;
                  end else begin
                     case (r_state)
                        S_ADDR: begin
                           w_stateNext = S_REG;
                           w_txLoad    = 1'b1;
                           w_txNext    = r_reg;
                        end
                        S_REG: begin
                           if (r_cnt == '0) begin
                              w_stateNext = S_STOP;
                           end else if (r_rw) begin
                              w_stateNext = S_RADDR;
                              w_txLoad    = 1'b1;
                              w_txNext    = {r_dev, 1'b1};
                           end else begin
                              w_stateNext = S_WREQ;
                           end
                        end
                        S_WDATA: begin
                           if (w_lastByte) begin
                              w_stateNext = S_STOP;
                           end else begin
                              w_cntDec    = 1'b1;
                              w_stateNext = S_WREQ;
                           end
                        end
                        default: begin
                           w_stateNext = S_READ;
                        end
                     endcase
                  end
               end
            endcase
         end
         S_WREQ: begin
            if (iWr_Valid) begin
               w_txLoad    = 1'b1;
               w_txNext    = iWr_Data;
               w_stateNext = S_WDATA;
            end
         end
         S_READ: begin
            if (r_phase == PH_ISSUE) begin
               if (iI2C_TxReady) begin
                  w_read      = 1'b1;
                  w_stop      = w_lastByte;
                  w_phaseNext = PH_WAIT;
               end else begin
                  w_tmo = w_expired;
               end
            end else begin
               if (iI2C_RxDone) begin
                  if (w_lastByte) begin
                     w_stateNext = S_STOP_WAIT;
                  end else begin
                     w_cntDec    = 1'b1;
                     w_phaseNext = PH_ISSUE;
                  end
               end else begin
                  w_tmo = w_expired;
               end
            end
         end
         S_STOP: begin
            if (iI2C_TxReady) begin
               w_stop      = 1'b1;
               w_stateNext = S_STOP_WAIT;
            end else begin
               w_tmo = w_expired;
            end
         end
         S_STOP_WAIT: begin
            if (r_timer == STOP_LAST) begin
               w_stateNext = S_DONE;
            end
         end
         S_DONE: begin
            w_stateNext = S_IDLE;
         end
         default: begin
            w_stateNext = S_IDLE;
         end
      endcase
      if (w_tmo) begin
         w_errSet = 1'b1;
         w_errVal = 2'd3;
         if (iI2C_TxReady) begin
            w_stop      = 1'b1;
            w_stateNext = S_STOP_WAIT;
         end else begin
            w_stateNext = S_DONE;
         end
      end
      if (w_stateNext != r_state) begin
         w_phaseNext = PH_ISSUE;
      end
   end

   // State, phase and the shared wait timer, which restarts on every state or
   // phase change and saturates so an idle controller never wraps it.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         r_state <= S_IDLE;
         r_phase <= PH_ISSUE;
         r_timer <= '0;
      end else begin
         r_state <= w_stateNext;
         r_phase <= w_phaseNext;
         if ((w_stateNext != r_state) || (w_phaseNext != r_phase)) begin
            r_timer <= '0;
         end else if (r_timer != '1) begin
            r_timer <= r_timer + 32'd1;
         end
      end
   end

   // Command latch, byte counter, transmit byte and error code. The error is
   // cleared only when the next command is accepted.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         r_dev    <= '0;
         r_reg    <= '0;
         r_rw     <= 1'b0;
         r_cnt    <= '0;
         r_txData <= '0;
         r_err    <= 2'd0;
      end else begin
         if (w_accept) begin
            r_dev <= iCmd_Dev;
            r_reg <= iCmd_Reg;
            r_rw  <= iCmd_Rw;
            r_cnt <= iCmd_Len;
            r_err <= 2'd0;
         end else begin
            if (w_cntDec) begin
               r_cnt <= r_cnt - LEN_W'(1);
            end
            if (w_errSet) begin
               r_err <= w_errVal;
            end
         end
         if (w_txLoad) begin
            r_txData <= w_txNext;
         end
      end
   end

   // Read capture: the byte is only valid during the master's RxDone pulse,
   // so it is registered and announced with a one-cycle valid afterwards.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         r_rdData  <= '0;
         r_rdValid <= 1'b0;
      end else begin
         r_rdValid <= w_rxCapture;
         if (w_rxCapture) begin
            r_rdData <= iI2C_RxData;
         end
      end
   end

   assign oCmd_Ready  = (r_state == S_IDLE);
   assign oBusy       = (r_state != S_IDLE);
   assign oWr_Ready   = (r_state == S_WREQ);
   assign oDone       = (r_state == S_DONE);
   assign oErr        = r_err;
   assign oRd_Data    = r_rdData;
   assign oRd_Valid   = r_rdValid;
   assign oI2C_Start  = w_start;
   assign oI2C_Write  = w_write;
   assign oI2C_Read   = w_read;
   assign oI2C_Stop   = w_stop;
   assign oI2C_TxData = r_txData;

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// tb_i2c_reg_ctrl: directed bench for i2c_reg_ctrl with a strobe-level I2C
// master/slave model, a write-data feeder and hand-computed expectations.
module tb_i2c_reg_ctrl;

   localparam int P_CLK    = 1_000_000;
   localparam int P_I2C    = 100_000;
   localparam int P_STOP   = 10;
   localparam int P_TMO    = 300;
   localparam int BYTE_CYC = 20;

   logic       iClk, iRst_n;
   logic       iCmd_Valid, iCmd_Rw;
   logic [6:0] iCmd_Dev;
   logic [7:0] iCmd_Reg;
   logic [3:0] iCmd_Len;
   logic [7:0] iWr_Data;
   logic       iWr_Valid;
   logic       iI2C_TxDone, iI2C_TxReady, iI2C_RxDone;
   logic [7:0] iI2C_RxData;
   logic       oCmd_Ready, oWr_Ready, oRd_Valid, oDone, oBusy;
   logic [7:0] oRd_Data, oI2C_TxData;
   logic [1:0] oErr;
   logic       oI2C_Start, oI2C_Write, oI2C_Read, oI2C_Stop;

   // Plan for the current transaction, owned by the main sequence.
   int         testGen;
   int         planNackAt, planHangAt, planWrCnt, planWrHold;
   logic [7:0] planRd [16];
   logic [7:0] planWr [16];

   // Observations, owned by the master model.
   int          cyc, txDoneCyc, doneCyc, doneCnt, stopStrobes, readStrobes, illegalCnt;
   logic [15:0] readStopMask;
   logic [7:0]  txLog [$];
   logic [7:0]  rdLog [$];

   // Feeder state.
   int wrIdx;

   int checkCount, errorCount;

   i2c_reg_ctrl #(
      .CLK_FREQ(P_CLK), .I2C_FREQ(P_I2C), .LEN_W(4), .TIMEOUT_CYC(P_TMO)
   ) dut (
      .iClk(iClk), .iRst_n(iRst_n),
      .iCmd_Valid(iCmd_Valid), .oCmd_Ready(oCmd_Ready), .iCmd_Rw(iCmd_Rw),
      .iCmd_Dev(iCmd_Dev), .iCmd_Reg(iCmd_Reg), .iCmd_Len(iCmd_Len),
      .iWr_Data(iWr_Data), .iWr_Valid(iWr_Valid), .oWr_Ready(oWr_Ready),
      .oRd_Data(oRd_Data), .oRd_Valid(oRd_Valid), .oDone(oDone), .oErr(oErr), .oBusy(oBusy),
      .oI2C_Start(oI2C_Start), .oI2C_Write(oI2C_Write), .oI2C_Read(oI2C_Read),
      .oI2C_Stop(oI2C_Stop), .oI2C_TxData(oI2C_TxData),
      .iI2C_TxDone(iI2C_TxDone), .iI2C_TxReady(iI2C_TxReady),
      .iI2C_RxDone(iI2C_RxDone), .iI2C_RxData(iI2C_RxData)
   );

   initial begin
      iClk = 1'b0;
      forever #5 iClk = ~iClk;
   end

   // Master + slave model: samples strobes on the falling edge, reacts just
   // after the next rising edge. A sent byte takes BYTE_CYC cycles, then
   // TxDone pulses and one cycle later TxReady shows ACK (1) or NACK (0).
   initial begin : masterModel
      int busy, post, byteIdx, rdIdx, seenGen;
      logic idle, isRead, stopReq, nextReady;
      logic sStart, sWrite, sRead, sStop, sReady;
      logic [7:0] sTx;
      iI2C_TxReady = 1'b0; iI2C_TxDone = 1'b0; iI2C_RxDone = 1'b0; iI2C_RxData = 8'h00;
      busy = 0; post = 0; byteIdx = 0; rdIdx = 0; seenGen = 0;
      idle = 1'b1; isRead = 1'b0; stopReq = 1'b0; nextReady = 1'b0;
      cyc = 0; txDoneCyc = 0; doneCyc = 0; doneCnt = 0; stopStrobes = 0;
      readStrobes = 0; illegalCnt = 0; readStopMask = '0;
      forever begin
         @(negedge iClk);
         cyc++;
         sStart = oI2C_Start; sWrite = oI2C_Write; sRead = oI2C_Read; sStop = oI2C_Stop;
         sReady = iI2C_TxReady; sTx = oI2C_TxData;
         if (iI2C_TxDone) txDoneCyc = cyc;
         if (oDone) begin doneCnt++; doneCyc = cyc; end
         if (oRd_Valid) rdLog.push_back(oRd_Data);
         @(posedge iClk);
         #1;
         iI2C_TxDone = 1'b0; iI2C_RxDone = 1'b0; iI2C_RxData = 8'hEE;
         if (testGen != seenGen) begin
            seenGen = testGen;
            txLog.delete(); rdLog.delete();
            doneCnt = 0; stopStrobes = 0; readStrobes = 0; readStopMask = '0;
            byteIdx = 0; rdIdx = 0; busy = 0; post = 0; idle = 1'b1; iI2C_TxReady = 1'b0;
            sStart = 1'b0; sWrite = 1'b0; sRead = 1'b0; sStop = 1'b0;
         end
         if (!iRst_n) begin
            iI2C_TxReady = 1'b0; idle = 1'b1; busy = 0; post = 0;
         end else begin
            if ((sStart || sWrite || sRead || sStop) &&
                (busy > 0 || post != 0 || (!sReady && !(sStart && idle)))) begin
               illegalCnt++;
            end
            if (post != 0) begin
               post = 0;
               iI2C_TxReady = nextReady;
               if (!nextReady) idle = 1'b1;
            end else if (busy > 0) begin
               busy--;
               if (busy == 0) begin
                  if (isRead) begin
                     iI2C_RxDone = 1'b1;
                     iI2C_RxData = (rdIdx < 16) ? planRd[rdIdx] : 8'h00;
                     rdIdx++;
                     nextReady = !stopReq;
                  end else begin
                     iI2C_TxDone = 1'b1;
                     nextReady = ((byteIdx - 1) != planNackAt);
                  end
                  post = 1;
               end
            end
            if (sStart || sWrite) begin
               txLog.push_back(sTx);
               byteIdx++;
               busy = ((byteIdx - 1) == planHangAt) ? 1_000_000 : BYTE_CYC;
               isRead = 1'b0; idle = 1'b0; iI2C_TxReady = 1'b0;
            end else if (sRead) begin
               if (readStrobes < 16 && sStop) readStopMask[readStrobes] = 1'b1;
               readStrobes++;
               stopReq = sStop; isRead = 1'b1; busy = BYTE_CYC; iI2C_TxReady = 1'b0;
            end else if (sStop) begin
               stopStrobes++;
               iI2C_TxReady = 1'b0; idle = 1'b1;
            end
         end
      end
   end

   // Write-data source: after an optional hold-off, keeps the next planned
   // byte valid until the controller takes it.
   initial begin : wrFeeder
      int hold, seenGen;
      logic fire;
      iWr_Valid = 1'b0; iWr_Data = 8'h00; wrIdx = 0; hold = 0; seenGen = 0;
      forever begin
         @(negedge iClk);
         fire = oWr_Ready && iWr_Valid;
         @(posedge iClk);
         #1;
         if (testGen != seenGen) begin
            seenGen = testGen; wrIdx = 0; hold = planWrHold; fire = 1'b0;
         end
         if (fire) wrIdx++;
         if (hold > 0) begin
            hold--; iWr_Valid = 1'b0;
         end else if (wrIdx < planWrCnt) begin
            iWr_Valid = 1'b1; iWr_Data = planWr[wrIdx];
         end else begin
            iWr_Valid = 1'b0;
         end
      end
   end

   // Single comparison point: counts and reports every check.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   // Starts a new transaction plan and presents one command for one cycle.
   task automatic applyStimulus(input logic rw, input logic [6:0] dev, input logic [7:0] regAddr,
                                input logic [3:0] len);
      testGen++;
      repeat (2) @(posedge iClk);
      #1;
      iCmd_Valid = 1'b1; iCmd_Rw = rw; iCmd_Dev = dev; iCmd_Reg = regAddr; iCmd_Len = len;
      @(posedge iClk);
      #1;
      iCmd_Valid = 1'b0;
   endtask

   // Waits (bounded) for oDone, then lets trailing activity settle.
   task automatic waitDone(input int budget);
      int n;
      logic seen;
      n = 0; seen = 1'b0;
      while (!seen && n < budget) begin
         @(negedge iClk);
         n++;
         if (oDone) seen = 1'b1;
      end
      checkOutput("doneSeen", 32'(seen), 32'd1);
      repeat (6) @(negedge iClk);
   endtask

   // Compares a logged byte sequence against up to four expected bytes.
   task automatic checkSeq(input string tag, input logic isRx, input int n, input logic [31:0] expSeq);
      int sz;
      logic [7:0] got;
      sz = isRx ? rdLog.size() : txLog.size();
      checkOutput({tag, "Len"}, 32'(sz), 32'(n));
      for (int i = 0; i < n; i++) begin
         if (i < sz) got = isRx ? rdLog[i] : txLog[i];
         else got = 8'hxx;
         checkOutput(tag, {24'h0, got}, {24'h0, expSeq[8*(n-1-i) +: 8]});
      end
   endtask

   // Output values that reset must produce, checked while reset is held.
   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "Ready"}, {31'h0, oCmd_Ready}, 32'd1);
      checkOutput({tag, "Busy"}, {31'h0, oBusy}, 32'd0);
      checkOutput({tag, "Err"}, {30'h0, oErr}, 32'd0);
      checkOutput({tag, "RdData"}, {24'h0, oRd_Data}, 32'd0);
      checkOutput({tag, "TxData"}, {24'h0, oI2C_TxData}, 32'd0);
      checkOutput({tag, "Strobes"}, {26'h0, oI2C_Start, oI2C_Write, oI2C_Read, oI2C_Stop, oRd_Valid, oDone}, 32'd0);
      checkOutput({tag, "WrReady"}, {31'h0, oWr_Ready}, 32'd0);
   endtask

   initial begin : mainSeq
      int n;
      checkCount = 0; errorCount = 0; testGen = 0;
      planNackAt = -1; planHangAt = -1; planWrCnt = 0; planWrHold = 0;
      for (int i = 0; i < 16; i++) begin planRd[i] = 8'h00; planWr[i] = 8'h00; end
      iCmd_Valid = 1'b0; iCmd_Rw = 1'b0; iCmd_Dev = 7'h0; iCmd_Reg = 8'h0; iCmd_Len = 4'h0;
      iRst_n = 1'b1;
      #1 iRst_n = 1'b0;
      repeat (3) @(negedge iClk);
      checkResetOutputs("rst");
      @(posedge iClk);
      #1 iRst_n = 1'b1;

      // Write Dev=0x50 Reg=0x10, two data bytes, all ACKed.
      planWr[0] = 8'hA5; planWr[1] = 8'h3C; planWrCnt = 2;
      applyStimulus(1'b0, 7'h50, 8'h10, 4'd2);
      waitDone(2000);
      checkSeq("wrTx", 1'b0, 4, 32'hA0_10_A5_3C);
      checkOutput("wrStops", 32'(stopStrobes), 32'd1);
      checkOutput("wrDone", 32'(doneCnt), 32'd1);
      checkOutput("wrErr", {30'h0, oErr}, 32'd0);

      // Read Dev=0x68 Reg=0x75, three bytes, Stop only with the third Read.
      planWrCnt = 0;
      planRd[0] = 8'h11; planRd[1] = 8'h22; planRd[2] = 8'h33;
      applyStimulus(1'b1, 7'h68, 8'h75, 4'd3);
      waitDone(2000);
      checkSeq("rdTx", 1'b0, 3, 32'h00_D0_75_D1);
      checkSeq("rdRx", 1'b1, 3, 32'h00_11_22_33);
      checkOutput("rdReads", 32'(readStrobes), 32'd3);
      checkOutput("rdStopMask", {16'h0, readStopMask}, 32'h4);
      checkOutput("rdStops", 32'(stopStrobes), 32'd0);
      checkOutput("rdErr", {30'h0, oErr}, 32'd0);

      // No slave at 0x21: NACK on the address byte, STOP wait, error 1.
      planNackAt = 0; planWr[0] = 8'h77; planWrCnt = 1;
      applyStimulus(1'b0, 7'h21, 8'h00, 4'd1);
      waitDone(2000);
      checkSeq("nackTx", 1'b0, 1, 32'h0000_0042);
      checkOutput("nackStops", 32'(stopStrobes), 32'd0);
      checkOutput("nackLat", 32'(doneCyc - txDoneCyc), 32'(P_STOP + 4));
      checkOutput("nackErr", {30'h0, oErr}, 32'd1);
      checkOutput("nackDone", 32'(doneCnt), 32'd1);

      // Write of three bytes, slave NACKs the second data byte.
      planNackAt = 3; planWr[0] = 8'h01; planWr[1] = 8'h02; planWr[2] = 8'h03; planWrCnt = 3;
      applyStimulus(1'b0, 7'h50, 8'h20, 4'd3);
      waitDone(2000);
      checkSeq("dnackTx", 1'b0, 4, 32'hA0_20_01_02);
      checkOutput("dnackTaken", 32'(wrIdx), 32'd2);
      checkOutput("dnackErr", {30'h0, oErr}, 32'd2);
      checkOutput("dnackDone", 32'(doneCnt), 32'd1);
      checkOutput("dnackStops", 32'(stopStrobes), 32'd0);

      // One-byte write whose data arrives after 10000 cycles: no timeout.
      planNackAt = -1; planWr[0] = 8'hC3; planWrCnt = 1; planWrHold = 10_000;
      applyStimulus(1'b0, 7'h50, 8'h12, 4'd1);
      waitDone(12_000);
      planWrHold = 0;
      checkSeq("holdTx", 1'b0, 3, 32'h00_A0_12_C3);
      checkOutput("holdErr", {30'h0, oErr}, 32'd0);
      checkOutput("holdStops", 32'(stopStrobes), 32'd1);

      // Master never finishes the register byte: timeout, no Stop possible.
      planHangAt = 1; planWr[0] = 8'h99; planWrCnt = 1;
      applyStimulus(1'b0, 7'h50, 8'h11, 4'd1);
      waitDone(2000);
      planHangAt = -1;
      checkOutput("tmoErr", {30'h0, oErr}, 32'd3);
      checkOutput("tmoStops", 32'(stopStrobes), 32'd0);
      checkOutput("tmoDone", 32'(doneCnt), 32'd1);
      checkSeq("tmoTx", 1'b0, 2, 32'h0000_A011);

      // Reset while the second byte of a read is in flight.
      planWrCnt = 0;
      applyStimulus(1'b1, 7'h68, 8'h75, 4'd3);
      n = 0;
      while (readStrobes < 2 && n < 2000) begin @(negedge iClk); n++; end
      checkOutput("rstReachRead2", 32'(readStrobes), 32'd2);
      repeat (5) @(negedge iClk);
      @(posedge iClk);
      #1 iRst_n = 1'b0;
      @(negedge iClk);
      checkResetOutputs("midRst");
      repeat (2) @(posedge iClk);
      #1 iRst_n = 1'b1;
      repeat (3) @(negedge iClk);
      checkOutput("midRstStops", 32'(stopStrobes), 32'd0);

      // Register-pointer-only write (Len=0) right after the reset.
      applyStimulus(1'b0, 7'h50, 8'h05, 4'd0);
      waitDone(2000);
      checkSeq("ptrTx", 1'b0, 2, 32'h0000_A005);
      checkOutput("ptrStops", 32'(stopStrobes), 32'd1);
      checkOutput("ptrTaken", 32'(wrIdx), 32'd0);
      checkOutput("ptrErr", {30'h0, oErr}, 32'd0);

      // Single-byte read: the only Read carries the Stop.
      planRd[0] = 8'h5C;
      applyStimulus(1'b1, 7'h3A, 8'h01, 4'd1);
      waitDone(2000);
      checkSeq("rd1Tx", 1'b0, 3, 32'h00_74_01_75);
      checkSeq("rd1Rx", 1'b1, 1, 32'h0000_005C);
      checkOutput("rd1StopMask", {16'h0, readStopMask}, 32'h1);
      checkOutput("rd1Err", {30'h0, oErr}, 32'd0);

      checkOutput("illegalStrobes", 32'(illegalCnt), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
